// File: rtl/countdown_pkg.sv
// Shared types and constants for the mm:ss:cc countdown timer.
// Holds the FSM state encoding, the BCD digit type and the preset clamp helper.
package countdown_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX     = 4'd9;
  localparam bcd_t SEC_HI_MAX  = 4'd5;
  localparam bcd_t BLANK       = 4'hF;
  localparam int   BLINK_TICKS = 50;

  function automatic bcd_t clamp_digit(input bcd_t d, input bcd_t max);
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between the key debouncers, the timer and the seven-segment decoders.
// master drives keys and preset; slave is the timer itself.
interface countdown_timer_if;

  logic        start_pulse;
  logic        load_pulse;
  logic [15:0] preset_bcd;
  logic [23:0] digits_bcd;
  logic        running;
  logic        expired;
  logic        done_pulse;

  modport master (
    output start_pulse, load_pulse, preset_bcd,
    input  digits_bcd, running, expired, done_pulse
  );

  modport slave (
    input  start_pulse, load_pulse, preset_bcd,
    output digits_bcd, running, expired, done_pulse
  );

endinterface

// File: rtl/countdown_timer_bcd_down_digit.sv
// One BCD digit of the decrementing borrow chain; MAX is the value a digit wraps to
// when it borrows from zero (9 for decimal digits, 5 for the tens-of-seconds digit).
module bcd_down_digit
  import countdown_pkg::*;
#(
  parameter bcd_t MAX = BCD_MAX
) (
  input  bcd_t digit,
  input  logic borrow_in,
  output bcd_t digit_next,
  output logic borrow_out
);

  always_comb begin
    digit_next = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == 4'd0) begin
        digit_next = MAX;
        borrow_out = 1'b1;
      end else begin
        digit_next = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Down-counting mm:ss:cc timer: loads a clamped BCD preset, decrements every TICK_DIV clocks
// while running and flags expiry. Optional EXPIRE_BLINK_EN blanks the display every 50 ticks in DONE.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int TICK_DIV = 500000
) (
  input logic              clk,
  input logic              reset_1_time,
  countdown_timer_if.slave bus
);

  localparam int             PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t        state_reg, state_next;
  bcd_t [5:0]    digits_reg, digits_next, digits_dec, digits_load;
  logic [PW-1:0] presc_reg, presc_next;
  logic          done_pulse_reg, done_pulse_next;
  logic          presc_wrap;
  logic          run_tick;
  logic [6:0]    borrow;

`ifdef EXPIRE_BLINK_EN
  localparam int             BW         = $clog2(BLINK_TICKS);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  logic [BW-1:0] blink_cnt_reg, blink_cnt_next;
  logic          blink_phase_reg, blink_phase_next;
`endif

  assign presc_wrap = (presc_reg == PRESC_LAST);
  assign run_tick   = (state_reg == RUN) && presc_wrap;
  assign borrow[0]  = run_tick;

  // Digit index 0 is cc_lo, 5 is min_hi; only sec_hi (index 3) wraps to 5.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_chain
      bcd_down_digit #(
        .MAX ((gi == 3) ? SEC_HI_MAX : BCD_MAX)
      ) u_digit (
        .digit      (digits_reg[gi]),
        .borrow_in  (borrow[gi]),
        .digit_next (digits_dec[gi]),
        .borrow_out (borrow[gi+1])
      );
    end

    for (gi = 0; gi < 4; gi++) begin : g_clamp
      assign digits_load[gi+2] = clamp_digit(bus.preset_bcd[gi*4 +: 4],
                                             (gi == 1) ? SEC_HI_MAX : BCD_MAX);
    end
  endgenerate

  assign digits_load[1:0] = '0;

  always_comb begin
    state_next      = state_reg;
    digits_next     = digits_reg;
    presc_next      = presc_reg;
    done_pulse_next = 1'b0;
`ifdef EXPIRE_BLINK_EN
    blink_cnt_next   = blink_cnt_reg;
    blink_phase_next = blink_phase_reg;
`endif
    if (bus.load_pulse) begin
      state_next  = IDLE;
      digits_next = digits_load;
      presc_next  = '0;
`ifdef EXPIRE_BLINK_EN
      blink_cnt_next   = '0;
      blink_phase_next = 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start_pulse && (digits_reg != '0)) state_next = RUN;
        end
        RUN: begin
          presc_next = presc_wrap ? '0 : presc_reg + PW'(1);
          // borrow[6] would mean an underflow from 00:00:00, which is never applied
          if (run_tick && !borrow[6]) digits_next = digits_dec;
          if (run_tick && (digits_dec == '0)) begin
            state_next      = DONE;
            done_pulse_next = 1'b1;
`ifdef EXPIRE_BLINK_EN
            blink_cnt_next   = '0;
            blink_phase_next = 1'b0;
`endif
          end else if (bus.start_pulse) begin
            state_next = PAUSE;
          end
        end
        PAUSE: begin
          if (bus.start_pulse) state_next = RUN;
        end
        DONE: begin
`ifdef EXPIRE_BLINK_EN
          presc_next = presc_wrap ? '0 : presc_reg + PW'(1);
          if (presc_wrap) begin
            if (blink_cnt_reg == BLINK_LAST) begin
              blink_cnt_next   = '0;
              blink_phase_next = ~blink_phase_reg;
            end else begin
              blink_cnt_next = blink_cnt_reg + BW'(1);
            end
          end
`endif
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_1_time) begin
    if (!reset_1_time) begin
      state_reg      <= IDLE;
      digits_reg     <= '0;
      presc_reg      <= '0;
      done_pulse_reg <= 1'b0;
`ifdef EXPIRE_BLINK_EN
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      digits_reg     <= digits_next;
      presc_reg      <= presc_next;
      done_pulse_reg <= done_pulse_next;
`ifdef EXPIRE_BLINK_EN
      blink_cnt_reg   <= blink_cnt_next;
      blink_phase_reg <= blink_phase_next;
`endif
    end
  end

  assign bus.running    = (state_reg == RUN);
  assign bus.expired    = (state_reg == DONE);
  assign bus.done_pulse = done_pulse_reg;

`ifdef EXPIRE_BLINK_EN
  assign bus.digits_bcd = blink_phase_reg ? {6{BLANK}} : digits_reg;
`else
  assign bus.digits_bcd = digits_reg;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random key presses, every cycle compared
// against a model that keeps the remaining time as an integer count of centiseconds.
module tb_countdown_timer;

  localparam int TICK_DIV   = 4;
  localparam int BLINK_CLKS = 50 * TICK_DIV;

  logic clk          = 1'b0;
  logic reset_1_time = 1'b0;

  countdown_timer_if bus ();

  countdown_timer #(
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk          (clk),
    .reset_1_time (reset_1_time),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: remaining time in centiseconds plus run/pause/done flags.
  int rem_cs;
  int frac;
  int done_clks;
  bit m_run;
  bit m_pause;
  bit m_done;
  bit m_pulse;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int preset_to_cs(input logic [15:0] p);
    int mh = (p[15:12] > 4'd9) ? 9 : int'(p[15:12]);
    int ml = (p[11:8]  > 4'd9) ? 9 : int'(p[11:8]);
    int sh = (p[7:4]   > 4'd5) ? 5 : int'(p[7:4]);
    int sl = (p[3:0]   > 4'd9) ? 9 : int'(p[3:0]);
    return (mh * 10 + ml) * 6000 + (sh * 10 + sl) * 100;
  endfunction

  function automatic logic [23:0] cs_to_bcd(input int cs);
    int m = cs / 6000;
    int s = (cs / 100) % 60;
    int c = cs % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic logic [23:0] exp_digits();
`ifdef EXPIRE_BLINK_EN
    if (m_done && ((done_clks / BLINK_CLKS) % 2 == 1)) return 24'hFFFFFF;
`endif
    return cs_to_bcd(rem_cs);
  endfunction

  task automatic model_reset();
    rem_cs    = 0;
    frac      = 0;
    done_clks = 0;
    m_run     = 0;
    m_pause   = 0;
    m_done    = 0;
    m_pulse   = 0;
  endtask

  task automatic model_step(input logic st, input logic ld, input logic [15:0] pre);
    m_pulse = 0;
    if (ld) begin
      rem_cs    = preset_to_cs(pre);
      frac      = 0;
      done_clks = 0;
      m_run     = 0;
      m_pause   = 0;
      m_done    = 0;
    end else if (m_done) begin
      done_clks++;
    end else if (m_run) begin
      frac++;
      if (frac == TICK_DIV) begin
        frac = 0;
        rem_cs--;
      end
      if (rem_cs == 0) begin
        m_run     = 0;
        m_done    = 1;
        m_pulse   = 1;
        done_clks = 0;
      end else if (st) begin
        m_run   = 0;
        m_pause = 1;
      end
    end else if (m_pause) begin
      if (st) begin
        m_pause = 0;
        m_run   = 1;
      end
    end else if (st && rem_cs != 0) begin
      m_run = 1;
    end
  endtask

  task automatic compare_all();
    check("digits",     32'(bus.digits_bcd), 32'(exp_digits()));
    check("running",    32'(bus.running),    32'(m_run));
    check("expired",    32'(bus.expired),    32'(m_done));
    check("done_pulse", 32'(bus.done_pulse), 32'(m_pulse));
  endtask

  // One clock: drive inputs, step the model on the edge, compare 1 time unit later.
  task automatic cycle(input logic st, input logic ld, input logic [15:0] pre);
    bus.start_pulse = st;
    bus.load_pulse  = ld;
    bus.preset_bcd  = pre;
    @(posedge clk);
    model_step(st, ld, pre);
    #1;
    compare_all();
    bus.start_pulse = 1'b0;
    bus.load_pulse  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running, expected summary");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    bus.start_pulse = 1'b0;
    bus.load_pulse  = 1'b0;
    bus.preset_bcd  = 16'h0000;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset_1_time = 1'b1;
    $display("reset released");

    $display("load 10:00, start, check borrow chain");
    cycle(0, 1, 16'h1000);
    check("load_1000", 32'(bus.digits_bcd), 32'h00100000);
    cycle(1, 0, 16'h0000);
    check("run_entry", 32'(bus.running), 32'd1);
    repeat (TICK_DIV) cycle(0, 0, 16'h0000);
    check("borrow_1", 32'(bus.digits_bcd), 32'h00095999);
    repeat (TICK_DIV) cycle(0, 0, 16'h0000);
    check("borrow_2", 32'(bus.digits_bcd), 32'h00095998);

    $display("async reset while running");
    #3 reset_1_time = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("reset_digits", 32'(bus.digits_bcd), 32'h0);
    @(posedge clk);
    #1;
    compare_all();
    reset_1_time = 1'b1;

    $display("load 00:01:00, run to expiry");
    cycle(0, 1, 16'h0000);
    cycle(0, 1, 16'h0001);
    check("load_0001", 32'(bus.digits_bcd), 32'h00000100);
    cycle(1, 0, 16'h0000);
    pulses = 0;
    for (int i = 0; i < 100 * TICK_DIV + 5; i++) begin
      cycle(0, 0, 16'h0000);
      if (bus.done_pulse) pulses++;
    end
    check("done_pulse_count", 32'(pulses), 32'd1);
    check("expired_sticky", 32'(bus.expired), 32'd1);
    check("expired_digits", 32'(bus.digits_bcd), 32'h0);
    cycle(1, 0, 16'h0000);
    check("start_in_done", 32'(bus.running), 32'd0);
    $display("dwell in DONE for blink phases");
    repeat (450) cycle(0, 0, 16'h0000);

    $display("pause and resume");
    cycle(0, 1, 16'h0001);
    cycle(1, 0, 16'h0000);
    repeat (10) cycle(0, 0, 16'h0000);
    cycle(1, 0, 16'h0000);
    check("paused_digits", 32'(bus.digits_bcd), 32'h00000098);
    check("paused_running", 32'(bus.running), 32'd0);
    repeat (20) cycle(0, 0, 16'h0000);
    check("pause_hold", 32'(bus.digits_bcd), 32'h00000098);
    cycle(1, 0, 16'h0000);
    cycle(0, 0, 16'h0000);
    check("resume_fraction", 32'(bus.digits_bcd), 32'h00000097);

    $display("clamp and priority");
    cycle(0, 1, 16'hFF7A);
    check("clamp", 32'(bus.digits_bcd), 32'h00995900);
    cycle(1, 0, 16'h0000);
    cycle(1, 1, 16'h0005);
    check("load_beats_start", 32'(bus.running), 32'd0);
    check("load_beats_digits", 32'(bus.digits_bcd), 32'h00000500);
    cycle(0, 1, 16'h0000);
    cycle(1, 0, 16'h0000);
    check("start_zero_ignored", 32'(bus.running), 32'd0);

    $display("random key presses");
    cycle(0, 1, 16'h0002);
    for (int i = 0; i < 20000; i++) begin
      logic        st;
      logic        ld;
      logic [15:0] pre;
      ld  = ($urandom_range(0, 999) == 0);
      st  = ($urandom_range(0, 29) == 0);
      pre = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                        : {12'h000, 4'($urandom_range(0, 2))};
      if (ld) $display("random load preset %h start %0b", pre, st);
      cycle(st, ld, pre);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
